// File: rtl/uart_receiver.sv
// UART receive stage: 8N1, LSB-first, OVERSAMPLE clocks per bit, with valid/ack handshake.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each mid-bit sample point.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] SAMPLE_PT = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] SAMPLE_PT = CW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_sync1;
  logic                 r_rxs;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_tick;
  logic                 w_sample;
  logic                 w_shift_en;
  logic                 w_load;
  logic                 w_ferr;
  logic                 w_clr_idx;

  assign w_tick = (r_cnt == SAMPLE_PT);
  assign busy   = (r_state != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
  // Holds rxs from the two clocks before the decision point; current rxs is the third vote.
  logic [1:0] r_maj;

  always_ff @(posedge clk) begin
    if (r_cnt == SAMPLE_PT - CW'(2) || r_cnt == SAMPLE_PT - CW'(1))
      r_maj <= {r_maj[0], r_rxs};
  end

  assign w_sample = (r_maj[1] & r_maj[0]) | (r_rxs & (r_maj[1] | r_maj[0]));
`else
  assign w_sample = r_rxs;
`endif

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    w_ferr     = 1'b0;
    w_clr_idx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rxs) w_next = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          w_clr_idx = 1'b1;
          w_next    = w_sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_idx == LAST_IDX) w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_sample) begin
            w_load = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_ferr = 1'b1;
            w_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (r_rxs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_rxs     <= 1'b1;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_rxs   <= r_sync1;
      r_state <= w_next;
      // The clock that first sees low rxs counts as cnt = 0.
      if (r_state == ST_IDLE)
        r_cnt <= r_rxs ? '0 : CW'(1);
      else if (r_state == ST_BREAK)
        r_cnt <= '0;
      else
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
      if (w_clr_idx)
        r_idx <= '0;
      else if (w_shift_en)
        r_idx <= r_idx + IW'(1);
      if (w_shift_en)
        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
      frame_err <= w_ferr;
      if (w_load) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule
